// File: rtl/img_mem_pkg.sv
// Constants and state encoding shared by the image writer and the readback path.
// Bank geometry, pixel width and the writer FSM state type live here.
package img_mem_pkg;

  localparam int ADDR_DEPTH = 480;
  localparam int NUM_MEMS   = 240;
  localparam int DATA_W     = 20;
  localparam int ADDR_W     = 10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_VAL  = 4'd1,
    ACK       = 4'd2,
    WAIT_DROP = 4'd3,
    ADVANCE   = 4'd4,
    DONE      = 4'd5
  } writer_state_t;

  // A word is malformed when anything above the pixel field is set.
  function automatic logic upper_bits_set(input logic [31:0] word);
    return |word[31:DATA_W];
  endfunction

endpackage

// File: rtl/bank_addr_counter.sv
// Word address / bank select pair that sweeps 0..DEPTH-1 within each bank, then
// moves to the next bank; 'last' flags the final word of the final bank.
module bank_addr_counter
  import img_mem_pkg::*;
#(
  parameter int DEPTH = ADDR_DEPTH,
  parameter int BANKS = NUM_MEMS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] which_mem,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] bank_q, bank_d;
  logic              addr_end;

  assign addr_end  = (addr_q == ADDR_W'(DEPTH - 1));
  assign last      = addr_end && (bank_q == ADDR_W'(BANKS - 1));
  assign addr      = addr_q;
  assign which_mem = bank_q;

  // Next address: clear wins, the final word wraps the whole sweep back to zero.
  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    if (clr) begin
      addr_d = {ADDR_W{1'b0}};
      bank_d = {ADDR_W{1'b0}};
    end else if (inc) begin
      if (last) begin
        addr_d = {ADDR_W{1'b0}};
        bank_d = {ADDR_W{1'b0}};
      end else if (addr_end) begin
        addr_d = {ADDR_W{1'b0}};
        bank_d = bank_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Address registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q <= {ADDR_W{1'b0}};
      bank_q <= {ADDR_W{1'b0}};
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
    end
  end

endmodule

// File: rtl/mem_writer.sv
// HPS-to-FPGA image loader: one pixel per four-phase arm_val/fpga_ack handshake,
// written sequentially across the M10K banks with a running checksum and format flag.
module mem_writer
  import img_mem_pkg::*;
#(
  parameter int DEPTH = ADDR_DEPTH,
  parameter int BANKS = NUM_MEMS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              arm_val,
  input  logic [31:0]       arm_data,
  output logic              fpga_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] which_mem,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              fmt_err,
  output logic [3:0]        state_dbg
);

  writer_state_t     state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic              fpga_ack_q, fpga_ack_d;
  logic              done_q, done_d;
  logic              fmt_err_q, fmt_err_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              cnt_inc, cnt_clr, cnt_last;

  bank_addr_counter #(
    .DEPTH(DEPTH),
    .BANKS(BANKS)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .addr     (addr),
    .which_mem(which_mem),
    .last     (cnt_last)
  );

  // Handshake FSM: next state and next register values.
  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    fpga_ack_d = fpga_ack_q;
    done_d     = done_q;
    fmt_err_d  = fmt_err_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        fpga_ack_d = 1'b0;
        if (start) begin
          cnt_clr    = 1'b1;
          checksum_d = 32'd0;
          fmt_err_d  = 1'b0;
          done_d     = 1'b0;
          state_d    = WAIT_VAL;
        end else begin
          state_d = state_q;
        end
      end
      WAIT_VAL: begin
        if (arm_val) begin
          wr_data_d  = arm_data[DATA_W-1:0];
          mem_we_d   = 1'b1;
          checksum_d = checksum_q + {{(32-DATA_W){1'b0}}, arm_data[DATA_W-1:0]};
          fmt_err_d  = fmt_err_q | upper_bits_set(arm_data);
          state_d    = ACK;
        end else begin
          state_d = WAIT_VAL;
        end
      end
      ACK: begin
        fpga_ack_d = 1'b1;
        state_d    = WAIT_DROP;
      end
      WAIT_DROP: begin
        // A held arm_val stalls here; no second write can be issued.
        if (!arm_val) begin
          fpga_ack_d = 1'b0;
          state_d    = ADVANCE;
        end else begin
          state_d = WAIT_DROP;
        end
      end
      ADVANCE: begin
        cnt_inc = 1'b1;
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT_VAL;
        end
      end
      default: begin
        state_d    = IDLE;
        fpga_ack_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_we_q   <= 1'b0;
      fpga_ack_q <= 1'b0;
      done_q     <= 1'b0;
      fmt_err_q  <= 1'b0;
      wr_data_q  <= {DATA_W{1'b0}};
      checksum_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      fpga_ack_q <= fpga_ack_d;
      done_q     <= done_d;
      fmt_err_q  <= fmt_err_d;
      wr_data_q  <= wr_data_d;
      checksum_q <= checksum_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign fpga_ack  = fpga_ack_q;
  assign done      = done_q;
  assign fmt_err   = fmt_err_q;
  assign wr_data   = wr_data_q;
  assign checksum  = checksum_q;
  assign state_dbg = state_q;

endmodule
